mult_rr_arbiter: RTL and testbench
==================================

Name: mult_rr_arbiter

Overview:
Round-robin scheduler that shares one mult_shift_add INT8x INT8 multiplier among NUM_REQ requesters (e.g. per-channel MAC lanes). It accepts operand pairs over per-requester valid/ready, drives the multiplier's valid/a/b, tracks the owner of the in-flight product and returns the 16-bit product to that owner over per-requester valid/ready with backpressure. Sits between lane controllers and the multiplier instance; it contains no arithmetic itself.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
IDX_W, $clog2(NUM_REQ), owner/pointer index width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_a  in  8*NUM_REQ  signed operand A, requester i at [8i+7:8i]
req_b  in  8*NUM_REQ  signed operand B, same packing
rsp_valid  out  NUM_REQ  product valid, one-hot to owner
rsp_ready  in  NUM_REQ  per-requester product accept
rsp_product  out  16  signed product (shared bus, qualified by rsp_valid)
mul_valid  out  1  to multiplier valid
mul_a  out  8  to multiplier a
mul_b  out  8  to multiplier b
mul_product  in  16  from multiplier product (held while valid low)
mul_done  in  1  from multiplier done (1 cycle after mul_valid)
err_done  out  1  sticky: mul_done seen with no op in flight

Behaviour:
- Reset (async, rst_n low): state IDLE, rr pointer 0, owner 0, req_ready 0, rsp_valid 0, mul_valid 0, mul_a/mul_b 0, err_done 0. Reset mid-operation abandons any in-flight op; no response is issued for it.
- FSM states: IDLE, WAIT (op issued, awaiting mul_done), RESP (product held, owner not yet accepted).
- "Issue slot" is open in IDLE, in WAIT when mul_done & rsp_ready[owner], and in RESP when rsp_ready[owner].
- Arbitration when issue slot open and any req_valid: winner = first set req_valid searching ptr, ptr+1, ... mod NUM_REQ. Combinationally: req_ready[winner]=1, mul_valid=1, mul_a/mul_b = winner's operands. At edge: owner<=winner, ptr<=(winner+1) mod NUM_REQ, state<=WAIT.
- req_ready is never asserted without the matching req_valid; at most one bit set; zero when slot closed.
- Slot open with no req_valid: state<=IDLE, ptr unchanged, mul_valid 0.
- WAIT: rsp_valid[owner]=mul_done, rsp_product=mul_product. mul_done & !rsp_ready[owner] -> RESP. !mul_done -> stay WAIT (tolerates longer multiplier latency).
- RESP: rsp_valid[owner]=1, rsp_product=mul_product (multiplier holds value since mul_valid=0); hold until rsp_ready[owner].
- Latency: operand accepted cycle t -> rsp_valid cycle t+1 (1-cycle multiplier). Throughput: 1 op/cycle when owners accept immediately (response pop and new issue in same cycle).
- rsp_product bus is don't-care-stable: drives mul_product in all states; only valid-qualified.
- Ptr wrap: NUM_REQ-1 -> 0. Ptr advances only on grant.
- err_done set when mul_done high in IDLE or RESP; sticky until reset; does not alter FSM.
- No arithmetic in block; product width/sign per multiplier (signed 16-bit).

Optional Feature:
MULT_ARB_PERF_EN: when defined, adds output grant_cnt (16*NUM_REQ): per-requester 16-bit saturating grant counters, incremented on each req_valid&req_ready, saturating at 16'hFFFF, reset to 0. When undefined, port and counters absent; all other behaviour identical.

Test Plan:
- Req 2 only, a=5 b=-3, rsp_ready tied 1 -> req_ready[2] at t, mul_valid t, rsp_valid=4'b0100 at t+1, rsp_product=-15, FSM back to IDLE.
- All 4 req_valid held, rsp_ready all 1, after reset -> grants 0,1,2,3,0 on consecutive cycles; one rsp per cycle to matching owner.
- Signed corners: (-128,-128)->16384, (-128,127)->-16256, (127,127)->16129, (0,-1)->0.
- Owner 1 holds rsp_ready low 5 cycles with req 3 pending -> rsp_valid[1] stays high, product stable, req_ready[3] low; release -> same cycle req_ready[3]=1, next rsp to 3.
- Assert rst_n low during WAIT -> all outputs 0 immediately; after release, no stale rsp, ptr=0 (req 0 wins first).
- Force mul_done in IDLE -> err_done=1 and stays 1; FSM unaffected; with MULT_ARB_PERF_EN, 70000 grants to req 0 -> grant_cnt[0]=16'hFFFF.

Source files
------------

// File: rtl/mult_rr_arbiter.sv
// Round-robin front end that shares one INT8 x INT8 multiplier among NUM_REQ lanes.
// Define MULT_ARB_PERF_EN to add per-requester saturating grant counters on grant_cnt.
module mult_rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [8*NUM_REQ-1:0]   req_a,
   input  logic [8*NUM_REQ-1:0]   req_b,
   output logic [NUM_REQ-1:0]     rsp_valid,
   input  logic [NUM_REQ-1:0]     rsp_ready,
   output logic [15:0]            rsp_product,
   output logic                   mul_valid,
   output logic [7:0]             mul_a,
   output logic [7:0]             mul_b,
   input  logic [15:0]            mul_product,
   input  logic                   mul_done,
   output logic                   err_done
`ifdef MULT_ARB_PERF_EN
   ,
   output logic [16*NUM_REQ-1:0]  grant_cnt
`endif
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic             err_q, err_d;

   logic [7:0]       op_a [NUM_REQ];
   logic [7:0]       op_b [NUM_REQ];
   logic [IDX_W-1:0] winner;
   logic             found;
   logic             owner_ready;
   logic             rsp_active;
   logic             slot_open;
   logic             grant;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
         assign op_a[gi]      = req_a[8*gi +: 8];
         assign op_b[gi]      = req_b[8*gi +: 8];
         assign req_ready[gi] = grant && (winner == IDX_W'(gi));
         assign rsp_valid[gi] = rsp_active && (owner_q == IDX_W'(gi));
      end
   endgenerate

   // Rotating priority search: first valid requester at or after the pointer.
   always_comb begin
      logic [IDX_W:0] cand_sum;
      winner   = '0;
      found    = 1'b0;
      cand_sum = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
         if (cand_sum >= NUM_REQ_W) begin
            cand_sum = cand_sum - NUM_REQ_W;
         end
         if (!found && req_valid[cand_sum[IDX_W-1:0]]) begin
            found  = 1'b1;
            winner = cand_sum[IDX_W-1:0];
         end
      end
   end

   assign owner_ready = rsp_ready[owner_q];
   assign rsp_active  = ((state_q == ST_WAIT) && mul_done) || (state_q == ST_RESP);

   always_comb begin
      slot_open = 1'b1;
      case (state_q)
         ST_IDLE: slot_open = 1'b1;
         ST_WAIT: slot_open = mul_done && owner_ready;
         ST_RESP: slot_open = owner_ready;
         default: slot_open = 1'b1;
      endcase
   end

   // Gating with rst_n keeps every handshake output quiet while reset is held.
   assign grant       = rst_n && slot_open && found;
   assign mul_valid   = grant;
   assign mul_a       = grant ? op_a[winner] : 8'd0;
   assign mul_b       = grant ? op_b[winner] : 8'd0;
   assign rsp_product = mul_product;
   assign err_done    = err_q;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      err_d   = err_q || (mul_done && (state_q != ST_WAIT));
      if (grant) begin
         state_d = ST_WAIT;
         owner_d = winner;
         ptr_d   = (winner == LAST_IDX) ? '0 : winner + IDX_W'(1);
      end else if (slot_open) begin
         state_d = ST_IDLE;
      end else if ((state_q == ST_WAIT) && mul_done) begin
         state_d = ST_RESP;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         err_q   <= err_d;
      end
   end

`ifdef MULT_ARB_PERF_EN
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_perf
         logic [15:0] cnt_q, cnt_d;
         always_comb begin
            cnt_d = cnt_q;
            if (req_valid[gi] && req_ready[gi] && (cnt_q != 16'hFFFF)) begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_q <= 16'd0;
            end else begin
               cnt_q <= cnt_d;
            end
         end
         assign grant_cnt[16*gi +: 16] = cnt_q;
      end
   endgenerate
`endif

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Bench for mult_rr_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_mult_rr_arbiter;
   localparam int N = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [N-1:0]      req_valid = '0;
   logic [N-1:0]      req_ready;
   logic [8*N-1:0]    req_a = '0;
   logic [8*N-1:0]    req_b = '0;
   logic [N-1:0]      rsp_valid;
   logic [N-1:0]      rsp_ready = '1;
   logic [15:0]       rsp_product;
   logic              mul_valid;
   logic [7:0]        mul_a, mul_b;
   logic [15:0]       mul_product;
   logic              mul_done;
   logic              err_done;
`ifdef MULT_ARB_PERF_EN
   logic [16*N-1:0]   grant_cnt;
`endif

   logic [15:0]       mprod_q;
   logic              mdone_q;
   logic              force_done = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mult_rr_arbiter #(.NUM_REQ(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_product (rsp_product),
      .mul_valid   (mul_valid),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_product (mul_product),
      .mul_done    (mul_done),
      .err_done    (err_done)
`ifdef MULT_ARB_PERF_EN
      ,
      .grant_cnt   (grant_cnt)
`endif
   );

   function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
      int r;
      r = int'($signed(a)) * int'($signed(b));
      return r[15:0];
   endfunction

   // One-cycle multiplier stand-in: product held while valid is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mprod_q <= 16'd0;
         mdone_q <= 1'b0;
      end else begin
         mdone_q <= mul_valid;
         if (mul_valid) mprod_q <= smul(mul_a, mul_b);
      end
   end
   assign mul_done    = mdone_q | force_done;
   assign mul_product = mprod_q;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: at most one product outstanding; it belongs to m_owner.
   int          m_ptr, m_owner;
   bit          m_busy, m_arrived, m_err;
   logic [15:0] m_prod;
   logic [15:0] m_cnt [N];

   always @(negedge clk) begin
      logic [N-1:0] rv_exp, rr_exp;
      int           win, idx;
      bit           open;
      if (!rst_n) begin
         m_ptr = 0; m_owner = 0; m_busy = 0; m_arrived = 0; m_err = 0; m_prod = '0;
         for (int i = 0; i < N; i++) m_cnt[i] = '0;
         chk("rst_req_ready", 32'(req_ready), 32'h0);
         chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
         chk("rst_mul_valid", 32'(mul_valid), 32'h0);
         chk("rst_mul_ab",    {16'h0, mul_a, mul_b}, 32'h0);
         chk("rst_err_done",  32'(err_done), 32'h0);
      end else begin
         rv_exp = (m_busy && (m_arrived || mul_done)) ? N'(1) << m_owner : '0;
         open   = !m_busy || ((rv_exp != 0) && rsp_ready[m_owner]);
         win    = -1;
         if (open) begin
            for (int k = 0; k < N; k++) begin
               idx = (m_ptr + k) % N;
               if (win < 0 && req_valid[idx]) win = idx;
            end
         end
         rr_exp = (win >= 0) ? N'(1) << win : '0;
         chk("mdl_req_ready", 32'(req_ready), 32'(rr_exp));
         chk("mdl_mul_valid", 32'(mul_valid), 32'(win >= 0));
         if (win >= 0) begin
            chk("mdl_mul_a", 32'(mul_a), 32'(req_a[8*win +: 8]));
            chk("mdl_mul_b", 32'(mul_b), 32'(req_b[8*win +: 8]));
         end
         chk("mdl_rsp_valid", 32'(rsp_valid), 32'(rv_exp));
         if (rv_exp != 0) chk("mdl_rsp_product", 32'(rsp_product), 32'(m_prod));
         chk("mdl_err_done", 32'(err_done), 32'(m_err));
`ifdef MULT_ARB_PERF_EN
         for (int i = 0; i < N; i++) chk("mdl_grant_cnt", 32'(grant_cnt[16*i +: 16]), 32'(m_cnt[i]));
`endif
         if (mul_done && !(m_busy && !m_arrived)) m_err = 1;
         if (m_busy && mul_done) m_arrived = 1;
         if ((rv_exp != 0) && rsp_ready[m_owner]) m_busy = 0;
         if (win >= 0) begin
            m_busy    = 1;
            m_arrived = 0;
            m_owner   = win;
            m_ptr     = (win + 1) % N;
            m_prod    = smul(req_a[8*win +: 8], req_b[8*win +: 8]);
            if (m_cnt[win] != 16'hFFFF) m_cnt[win] = m_cnt[win] + 16'd1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
      req_a[8*i +: 8] = a;
      req_b[8*i +: 8] = b;
   endtask

   int          g_seq [5] = '{0, 1, 2, 3, 0};
   logic [7:0]  c_a   [4] = '{8'h80, 8'h80, 8'h7F, 8'h00};
   logic [7:0]  c_b   [4] = '{8'h80, 8'h7F, 8'h7F, 8'hFF};
   logic [15:0] c_p   [4] = '{16'h4000, 16'hC080, 16'h3F01, 16'h0000};

   initial begin
      repeat (3) @(negedge clk);
      tick();
      rst_n = 1'b1;

      // Single requester 2: 5 * -3
      set_req(2, 8'd5, 8'hFD);
      req_valid = 4'b0100;
      @(negedge clk);
      chk("t1_grant", 32'(req_ready), 32'h4);
      chk("t1_mul_a", 32'(mul_a), 32'h05);
      tick();
      req_valid = '0;
      @(negedge clk);
      chk("t1_rsp_valid", 32'(rsp_valid), 32'h4);
      chk("t1_product", 32'(rsp_product), 32'hFFF1);
      tick();
      @(negedge clk);
      chk("t1_idle", 32'(rsp_valid), 32'h0);
      tick();

      // Fresh reset, then all four requesting: grants rotate 0,1,2,3,0
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 8'(i + 1), 8'd10);
      req_valid = 4'hF;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         chk("t2_grant", 32'(req_ready), 32'(1) << g_seq[s]);
         chk("t2_rsp", 32'(rsp_valid), (s == 0) ? 32'h0 : 32'(1) << g_seq[s-1]);
         tick();
      end
      req_valid = '0;
      @(negedge clk);
      chk("t2_last_rsp", 32'(rsp_valid), 32'h1);
      chk("t2_last_prod", 32'(rsp_product), 32'd10);
      tick();

      // Signed corner products through requester 0
      for (int c = 0; c < 4; c++) begin
         set_req(0, c_a[c], c_b[c]);
         req_valid = 4'b0001;
         @(negedge clk);
         chk("t3_grant", 32'(req_ready), 32'h1);
         tick();
         req_valid = '0;
         @(negedge clk);
         chk("t3_rsp_valid", 32'(rsp_valid), 32'h1);
         chk("t3_product", 32'(rsp_product), 32'(c_p[c]));
         tick();
      end

      // Owner 1 stalls its response for five cycles while requester 3 waits
      set_req(1, 8'd7, 8'hF7);
      set_req(3, 8'hEC, 8'd6);
      req_valid = 4'b0010;
      rsp_ready = 4'b1101;
      @(negedge clk);
      chk("t4_grant1", 32'(req_ready), 32'h2);
      tick();
      req_valid = 4'b1000;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("t4_hold_valid", 32'(rsp_valid), 32'h2);
         chk("t4_hold_prod", 32'(rsp_product), 32'hFFC1);
         chk("t4_no_grant", 32'(req_ready), 32'h0);
         tick();
      end
      rsp_ready = 4'hF;
      @(negedge clk);
      chk("t4_grant3", 32'(req_ready), 32'h8);
      chk("t4_pop1", 32'(rsp_valid), 32'h2);
      tick();
      req_valid = '0;
      @(negedge clk);
      chk("t4_rsp3", 32'(rsp_valid), 32'h8);
      chk("t4_prod3", 32'(rsp_product), 32'hFF88);
      tick();

      // Reset while an op is in flight
      set_req(2, 8'd9, 8'd9);
      req_valid = 4'b0100;
      @(negedge clk);
      chk("t5_grant2", 32'(req_ready), 32'h4);
      tick();
      rst_n = 1'b0;
      set_req(0, 8'd3, 8'd4);
      set_req(3, 8'd5, 8'd5);
      req_valid = 4'b1001;
      @(negedge clk);
      chk("t5_rst_ready", 32'(req_ready), 32'h0);
      chk("t5_rst_rsp", 32'(rsp_valid), 32'h0);
      chk("t5_rst_mulv", 32'(mul_valid), 32'h0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5_ptr0_grant", 32'(req_ready), 32'h1);
      chk("t5_no_stale", 32'(rsp_valid), 32'h0);
      tick();
      req_valid = '0;
      @(negedge clk);
      chk("t5_rsp0", 32'(rsp_valid), 32'h1);
      chk("t5_prod0", 32'(rsp_product), 32'd12);
      tick();

      // Spurious mul_done while idle
      force_done = 1'b1;
      @(negedge clk);
      chk("t6_err_before", 32'(err_done), 32'h0);
      tick();
      force_done = 1'b0;
      set_req(1, 8'd2, 8'd3);
      req_valid = 4'b0010;
      @(negedge clk);
      chk("t6_err_set", 32'(err_done), 32'h1);
      chk("t6_grant", 32'(req_ready), 32'h2);
      tick();
      req_valid = '0;
      @(negedge clk);
      chk("t6_rsp", 32'(rsp_valid), 32'h2);
      chk("t6_prod", 32'(rsp_product), 32'd6);
      chk("t6_err_sticky", 32'(err_done), 32'h1);
      tick();

      // Mixed request / backpressure patterns, checked by the model
      for (int i = 0; i < 40; i++) begin
         for (int j = 0; j < N; j++) set_req(j, 8'(i * 13 + j * 29 - 100), 8'(i * 7 - j * 41));
         req_valid = 4'((i * 7 + 3) % 16);
         rsp_ready = 4'((i * 5 + 1) % 16) | ((i % 3 == 0) ? 4'hF : 4'h0);
         @(negedge clk);
         tick();
      end
      req_valid = '0;
      rsp_ready = 4'hF;
      repeat (3) tick();

`ifdef MULT_ARB_PERF_EN
      // Saturate requester 0's grant counter
      req_valid = 4'b0001;
      repeat (70000) tick();
      req_valid = '0;
      @(negedge clk);
      chk("t7_grant_cnt_sat", 32'(grant_cnt[15:0]), 32'hFFFF);
      tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
